bullet_pool: RTL and testbench

Parametrised bullet manager that replaces per-bullet instances with one pool of NUM_TANKS x SLOTS_PER_TANK bullet slots. It handles slot allocation on fire, per-tank cooldown, per-frame motion, wall bounce, lifetime expiry, off-screen kill and hit clear. It sits between the tank modules, the per-slot wall collision logic and the colour mapper.

---
 rtl/bullet_pool_pkg.sv | 17 +
 rtl/bullet_pool_if.sv | 39 +++
 rtl/bullet_pool_slot.sv | 107 ++++++++++
 rtl/bullet_pool.sv | 123 ++++++++++++
 tb/tb_bullet_pool.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bullet_pool_pkg.sv
// Shared types and screen limits for the bullet pool and its slots.
package bullet_pool_pkg;
  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COORD_W-1:0] step_t;

  localparam coord_t SCREEN_W = coord_t'(640);
  localparam coord_t SCREEN_H = coord_t'(480);

  // Sign-extend an 8-bit direction component and scale it down to a per-frame step.
  function automatic step_t sext_shift(input logic signed [7:0] dir, input int shift);
    step_t s;
    s = step_t'(dir);
    return s >>> shift;
  endfunction
endpackage

// File: rtl/bullet_pool_if.sv
// Bundle of frame, tank, collision and bullet-state signals around the bullet pool.
interface bullet_pool_if
  import bullet_pool_pkg::*;
#(
  parameter int NUM_TANKS      = 2,
  parameter int SLOTS_PER_TANK = 3
) ();
  localparam int NS    = NUM_TANKS * SLOTS_PER_TANK;
  localparam int CNT_W = $clog2(SLOTS_PER_TANK + 1);

  logic                         frame_tick;
  logic                         game_reset;
  logic [NUM_TANKS-1:0]         fire;
  logic [NUM_TANKS*COORD_W-1:0] tank_x;
  logic [NUM_TANKS*COORD_W-1:0] tank_y;
  logic [NUM_TANKS*8-1:0]       sin;
  logic [NUM_TANKS*8-1:0]       cos;
  logic [NS-1:0]                wall_hit_x;
  logic [NS-1:0]                wall_hit_y;
  logic [NS-1:0]                hit_clear;
  logic [NS*COORD_W-1:0]        bullet_x;
  logic [NS*COORD_W-1:0]        bullet_y;
  logic [NS-1:0]                bullet_active;
  logic [NS*COORD_W-1:0]        bullet_step_x;
  logic [NS*COORD_W-1:0]        bullet_step_y;
  logic [NUM_TANKS*CNT_W-1:0]   live_count;

  modport master (
    output frame_tick, game_reset, fire, tank_x, tank_y, sin, cos,
           wall_hit_x, wall_hit_y, hit_clear,
    input  bullet_x, bullet_y, bullet_active, bullet_step_x, bullet_step_y, live_count
  );

  modport slave (
    input  frame_tick, game_reset, fire, tank_x, tank_y, sin, cos,
           wall_hit_x, wall_hit_y, hit_clear,
    output bullet_x, bullet_y, bullet_active, bullet_step_x, bullet_step_y, live_count
  );
endinterface

// File: rtl/bullet_pool_slot.sv
// One bullet slot: position, step, age and valid flag, updated once per frame tick.
module bullet_slot
  import bullet_pool_pkg::*;
#(
  parameter int LIFETIME = 300
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   tick_i,
  input  logic   clear_i,
  input  logic   hit_clear_i,
  input  logic   wall_x_i,
  input  logic   wall_y_i,
  input  logic   alloc_i,
  input  coord_t alloc_x_i,
  input  coord_t alloc_y_i,
  input  step_t  alloc_sx_i,
  input  step_t  alloc_sy_i,
  output coord_t x_o,
  output coord_t y_o,
  output step_t  sx_o,
  output step_t  sy_o,
  output logic   active_o,
  output logic   active_nxt_o
);
  localparam int TW = $clog2(LIFETIME + 1);
  localparam logic [TW-1:0] LAST_AGE = TW'(LIFETIME - 1);

  coord_t          x_q, x_d, y_q, y_d, nx, ny;
  step_t           sx_q, sx_d, sy_q, sy_d, sx_n, sy_n;
  logic [TW-1:0]   timer_q, timer_d;
  logic            active_q, active_d;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    timer_d  = timer_q;
    active_d = active_q;
    sx_n     = sx_q;
    sy_n     = sy_q;
    nx       = x_q;
    ny       = y_q;
    if (clear_i) begin
      x_d      = '0;
      y_d      = '0;
      sx_d     = '0;
      sy_d     = '0;
      timer_d  = '0;
      active_d = 1'b0;
    end else if (tick_i) begin
      if (active_q) begin
        if (hit_clear_i) begin
          active_d = 1'b0;
        end else if (timer_q == LAST_AGE) begin
          active_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
          sx_n    = wall_x_i ? -sx_q : sx_q;
          sy_n    = wall_y_i ? -sy_q : sy_q;
          nx      = x_q + coord_t'(sx_n);
          ny      = y_q + coord_t'(sy_n);
          x_d     = nx;
          y_d     = ny;
          sx_d    = sx_n;
          sy_d    = sy_n;
          // Unsigned compare also catches wrap-around below zero.
          if ((nx >= SCREEN_W) || (ny >= SCREEN_H)) active_d = 1'b0;
        end
      end
      if (alloc_i) begin
        x_d      = alloc_x_i;
        y_d      = alloc_y_i;
        sx_d     = alloc_sx_i;
        sy_d     = alloc_sy_i;
        timer_d  = '0;
        active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q      <= '0;
      y_q      <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      timer_q  <= '0;
      active_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      timer_q  <= timer_d;
      active_q <= active_d;
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign sx_o         = sx_q;
  assign sy_o         = sy_q;
  assign active_o     = active_q;
  assign active_nxt_o = active_d;
endmodule

// File: rtl/bullet_pool.sv
// Shared bullet pool: per-tank slot allocation, fire cooldown and live-bullet counts.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int NUM_TANKS      = 2,
  parameter int SLOTS_PER_TANK = 3,
  parameter int LIFETIME       = 300,
  parameter int COOLDOWN       = 35,
  parameter int VEL_SHIFT      = 5
) (
  input logic          clk_i,
  input logic          rst_i,
  bullet_pool_if.slave bus
);
  localparam int NS    = NUM_TANKS * SLOTS_PER_TANK;
  localparam int CNT_W = $clog2(SLOTS_PER_TANK + 1);
  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic [CD_W-1:0]            cd_q [NUM_TANKS];
  logic [CD_W-1:0]            cd_d [NUM_TANKS];
  logic [NUM_TANKS-1:0]       found;
  logic [NS-1:0]              alloc, active, active_nxt;
  logic [NUM_TANKS*CNT_W-1:0] live_q, live_d;
  coord_t                     ax [NUM_TANKS];
  coord_t                     ay [NUM_TANKS];
  step_t                      asx [NUM_TANKS];
  step_t                      asy [NUM_TANKS];
  coord_t                     x_s [NS];
  coord_t                     y_s [NS];
  step_t                      sx_s [NS];
  step_t                      sy_s [NS];

  for (genvar t = 0; t < NUM_TANKS; t++) begin : g_tank
    assign ax[t]  = bus.tank_x[t*COORD_W +: COORD_W];
    assign ay[t]  = bus.tank_y[t*COORD_W +: COORD_W];
    assign asx[t] = sext_shift(bus.cos[t*8 +: 8], VEL_SHIFT);
    assign asy[t] = sext_shift(bus.sin[t*8 +: 8], VEL_SHIFT);
  end

  // A slot being hit-cleared this tick counts as free, so a fire can reuse it immediately.
  always_comb begin
    alloc = '0;
    found = '0;
    for (int t = 0; t < NUM_TANKS; t++) begin
      cd_d[t] = cd_q[t];
      if (bus.fire[t] && (cd_q[t] == '0)) begin
        for (int s = 0; s < SLOTS_PER_TANK; s++) begin
          if (!found[t] && (!active[t*SLOTS_PER_TANK+s] || bus.hit_clear[t*SLOTS_PER_TANK+s])) begin
            alloc[t*SLOTS_PER_TANK+s] = 1'b1;
            found[t]                  = 1'b1;
          end
        end
      end
      if (bus.game_reset) begin
        cd_d[t] = '0;
      end else if (bus.frame_tick) begin
        if (found[t])              cd_d[t] = CD_LOAD;
        else if (cd_q[t] != '0)    cd_d[t] = cd_q[t] - CD_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NS; i++) begin : g_slot
    bullet_slot #(.LIFETIME(LIFETIME)) u_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .tick_i       (bus.frame_tick),
      .clear_i      (bus.game_reset),
      .hit_clear_i  (bus.hit_clear[i]),
      .wall_x_i     (bus.wall_hit_x[i]),
      .wall_y_i     (bus.wall_hit_y[i]),
      .alloc_i      (alloc[i]),
      .alloc_x_i    (ax[i/SLOTS_PER_TANK]),
      .alloc_y_i    (ay[i/SLOTS_PER_TANK]),
      .alloc_sx_i   (asx[i/SLOTS_PER_TANK]),
      .alloc_sy_i   (asy[i/SLOTS_PER_TANK]),
      .x_o          (x_s[i]),
      .y_o          (y_s[i]),
      .sx_o         (sx_s[i]),
      .sy_o         (sy_s[i]),
      .active_o     (active[i]),
      .active_nxt_o (active_nxt[i])
    );
  end

  // Counting next-state flags keeps live_count aligned with the slot registers.
  always_comb begin
    live_d = '0;
    for (int t = 0; t < NUM_TANKS; t++) begin
      for (int s = 0; s < SLOTS_PER_TANK; s++) begin
        live_d[t*CNT_W +: CNT_W] = live_d[t*CNT_W +: CNT_W]
                                 + CNT_W'(active_nxt[t*SLOTS_PER_TANK+s]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q <= '0;
      for (int t = 0; t < NUM_TANKS; t++) cd_q[t] <= '0;
    end else begin
      live_q <= live_d;
      for (int t = 0; t < NUM_TANKS; t++) cd_q[t] <= cd_d[t];
    end
  end

  always_comb begin
    bus.bullet_x      = '0;
    bus.bullet_y      = '0;
    bus.bullet_step_x = '0;
    bus.bullet_step_y = '0;
    for (int i = 0; i < NS; i++) begin
      bus.bullet_x[i*COORD_W +: COORD_W]      = x_s[i];
      bus.bullet_y[i*COORD_W +: COORD_W]      = y_s[i];
      bus.bullet_step_x[i*COORD_W +: COORD_W] = sx_s[i];
      bus.bullet_step_y[i*COORD_W +: COORD_W] = sy_s[i];
    end
  end

  assign bus.bullet_active = active;
  assign bus.live_count    = live_q;
endmodule

// File: tb/tb_bullet_pool.sv
// Directed and random stimulus for bullet_pool, checked against a frame-level model.
module tb_bullet_pool;
  import bullet_pool_pkg::*;

  localparam int NT   = 2;
  localparam int SPT  = 3;
  localparam int NS   = NT * SPT;
  localparam int CW   = COORD_W;
  localparam int LW   = 2;
  localparam int LIFE = 300;
  localparam int CDN  = 35;
  localparam int VS   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  bullet_pool_if #(.NUM_TANKS(NT), .SLOTS_PER_TANK(SPT)) bus ();

  bullet_pool #(
    .NUM_TANKS(NT), .SLOTS_PER_TANK(SPT), .LIFETIME(LIFE),
    .COOLDOWN(CDN), .VEL_SHIFT(VS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one record per slot, frames counted since allocation.
  int m_x [NS];
  int m_y [NS];
  int m_sx [NS];
  int m_sy [NS];
  int m_age [NS];
  int m_act [NS];
  int m_cd [NT];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] o_x(input int i);
    return {{(32-CW){1'b0}}, bus.bullet_x[i*CW +: CW]};
  endfunction
  function automatic logic signed [31:0] o_y(input int i);
    return {{(32-CW){1'b0}}, bus.bullet_y[i*CW +: CW]};
  endfunction
  function automatic logic signed [31:0] o_sx(input int i);
    return {{(32-CW){bus.bullet_step_x[i*CW+CW-1]}}, bus.bullet_step_x[i*CW +: CW]};
  endfunction
  function automatic logic signed [31:0] o_sy(input int i);
    return {{(32-CW){bus.bullet_step_y[i*CW+CW-1]}}, bus.bullet_step_y[i*CW +: CW]};
  endfunction
  function automatic logic signed [31:0] o_act(input int i);
    return {31'b0, bus.bullet_active[i]};
  endfunction
  function automatic logic signed [31:0] o_live(input int t);
    return {{(32-LW){1'b0}}, bus.live_count[t*LW +: LW]};
  endfunction

  function automatic int step_of(input logic [7:0] v);
    int s;
    s = int'($signed(v));
    return s >>> VS;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_sx[i] = 0; m_sy[i] = 0; m_age[i] = 0; m_act[i] = 0;
    end
    for (int t = 0; t < NT; t++) m_cd[t] = 0;
  endtask

  task automatic model_tick();
    int was [NS];
    int done;
    for (int i = 0; i < NS; i++) was[i] = m_act[i];
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] != 0) begin
        if (bus.hit_clear[i]) begin
          m_act[i] = 0;
        end else begin
          m_age[i]++;
          if (m_age[i] == LIFE) begin
            m_act[i] = 0;
          end else begin
            if (bus.wall_hit_x[i]) m_sx[i] = -m_sx[i];
            if (bus.wall_hit_y[i]) m_sy[i] = -m_sy[i];
            m_x[i] = (m_x[i] + m_sx[i]) & 1023;
            m_y[i] = (m_y[i] + m_sy[i]) & 1023;
            if (m_x[i] >= 640 || m_y[i] >= 480) m_act[i] = 0;
          end
        end
      end
    end
    for (int t = 0; t < NT; t++) begin
      done = 0;
      if (bus.fire[t] && m_cd[t] == 0) begin
        for (int s = 0; s < SPT; s++) begin
          if (done == 0 && (was[t*SPT+s] == 0 || bus.hit_clear[t*SPT+s])) begin
            m_x[t*SPT+s]   = int'(bus.tank_x[t*CW +: CW]);
            m_y[t*SPT+s]   = int'(bus.tank_y[t*CW +: CW]);
            m_sx[t*SPT+s]  = step_of(bus.cos[t*8 +: 8]);
            m_sy[t*SPT+s]  = step_of(bus.sin[t*8 +: 8]);
            m_age[t*SPT+s] = 0;
            m_act[t*SPT+s] = 1;
            done = 1;
          end
        end
      end
      if (done != 0)      m_cd[t] = CDN;
      else if (m_cd[t] > 0) m_cd[t]--;
    end
  endtask

  task automatic compare_all(input string ph);
    int cnt;
    for (int i = 0; i < NS; i++) begin
      check($sformatf("%s act[%0d]", ph, i), o_act(i), m_act[i]);
      check($sformatf("%s x[%0d]", ph, i),   o_x(i),   m_x[i]);
      check($sformatf("%s y[%0d]", ph, i),   o_y(i),   m_y[i]);
      check($sformatf("%s sx[%0d]", ph, i),  o_sx(i),  m_sx[i]);
      check($sformatf("%s sy[%0d]", ph, i),  o_sy(i),  m_sy[i]);
    end
    for (int t = 0; t < NT; t++) begin
      cnt = 0;
      for (int s = 0; s < SPT; s++) cnt += m_act[t*SPT+s];
      check($sformatf("%s live[%0d]", ph, t), o_live(t), cnt);
    end
  endtask

  task automatic set_tank(input int t, input logic [9:0] x, input logic [9:0] y,
                          input logic [7:0] c, input logic [7:0] s);
    bus.tank_x[t*CW +: CW] = x;
    bus.tank_y[t*CW +: CW] = y;
    bus.cos[t*8 +: 8]      = c;
    bus.sin[t*8 +: 8]      = s;
  endtask

  task automatic do_tick(input string ph);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    model_tick();
    bus.wall_hit_x = '0;
    bus.wall_hit_y = '0;
    bus.hit_clear  = '0;
    compare_all(ph);
  endtask

  task automatic do_game_reset();
    @(negedge clk);
    bus.game_reset = 1'b1;
    @(posedge clk);
    #1;
    bus.game_reset = 1'b0;
    model_reset();
    compare_all("game_reset");
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.game_reset = 1'b0;
    bus.fire       = '0;
    bus.tank_x     = '0;
    bus.tank_y     = '0;
    bus.sin        = '0;
    bus.cos        = '0;
    bus.wall_hit_x = '0;
    bus.wall_hit_y = '0;
    bus.hit_clear  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // First shot: slot0 spawns at the tank, then moves 2 px per frame.
    set_tank(0, 10'd100, 10'd200, 8'd64, 8'd0);
    bus.fire[0] = 1'b1;
    do_tick("fire0");
    check("spawn act0", o_act(0), 1);
    check("spawn x0", o_x(0), 100);
    check("spawn y0", o_y(0), 200);
    check("spawn sx0", o_sx(0), 2);
    check("spawn sy0", o_sy(0), 0);
    check("spawn live0", o_live(0), 1);
    bus.fire[0] = 1'b0;
    repeat (3) do_tick("move");
    check("moved x0", o_x(0), 106);

    // Held fire: allocations only on tick 0 and tick 36.
    do_game_reset();
    set_tank(0, 10'd100, 10'd200, 8'd0, 8'd0);
    bus.fire[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      do_tick("cooldown");
      if (k == 0)  check("cd live t0", o_live(0), 1);
      if (k == 35) check("cd live t35", o_live(0), 1);
      if (k == 36) check("cd live t36", o_live(0), 2);
    end
    bus.fire[0] = 1'b0;

    // Tank1 full: firing is dropped; a hit-cleared slot is reused lowest-first.
    do_game_reset();
    set_tank(1, 10'd50, 10'd60, 8'd0, 8'd0);
    bus.fire[1] = 1'b1;
    for (int k = 0; k < 109; k++) do_tick("fill1");
    check("full live1", o_live(1), 3);
    bus.fire[1] = 1'b0;
    bus.hit_clear[4] = 1'b1;
    do_tick("kill4");
    check("kill act4", o_act(4), 0);
    check("kill live1", o_live(1), 2);
    bus.fire[1] = 1'b1;
    do_tick("reuse4");
    check("reuse act4", o_act(4), 1);
    check("reuse live1", o_live(1), 3);
    bus.fire[1] = 1'b0;

    // Double wall bounce, step (2,-3) -> (-2,3). 8'hA0 is -96.
    do_game_reset();
    set_tank(0, 10'd300, 10'd300, 8'd64, 8'hA0);
    bus.fire[0] = 1'b1;
    do_tick("wall spawn");
    bus.fire[0] = 1'b0;
    bus.wall_hit_x[0] = 1'b1;
    bus.wall_hit_y[0] = 1'b1;
    do_tick("wall");
    check("wall sx0", o_sx(0), -2);
    check("wall sy0", o_sy(0), 3);
    check("wall x0", o_x(0), 298);
    check("wall y0", o_y(0), 303);

    // Leaving the screen on the right edge and wrapping off the top.
    do_game_reset();
    set_tank(0, 10'd638, 10'd100, 8'd64, 8'd0);
    set_tank(1, 10'd100, 10'd1, 8'd0, 8'hA0);
    bus.fire = 2'b11;
    do_tick("edge spawn");
    bus.fire = 2'b00;
    do_tick("edge");
    check("edge x0", o_x(0), 640);
    check("edge act0", o_act(0), 0);
    check("edge y3", o_y(3), 1022);
    check("edge act3", o_act(3), 0);

    // Stationary bullet lives exactly LIFETIME frames.
    do_game_reset();
    set_tank(0, 10'd10, 10'd10, 8'd0, 8'd0);
    bus.fire[0] = 1'b1;
    do_tick("life spawn");
    bus.fire[0] = 1'b0;
    for (int k = 1; k < LIFE; k++) do_tick("life");
    check("life act t299", o_act(0), 1);
    do_tick("life end");
    check("life act t300", o_act(0), 0);

    // Mid-flight game_reset clears everything on the next clock.
    set_tank(0, 10'd200, 10'd200, 8'd40, 8'd20);
    set_tank(1, 10'd400, 10'd300, 8'd200, 8'd100);
    bus.fire = 2'b11;
    do_tick("pre clr");
    bus.fire = 2'b00;
    do_tick("pre clr");
    do_game_reset();
    check("clr active", {26'b0, bus.bullet_active}, 0);

    // Random frames with idle cycles of junk inputs between ticks.
    for (int k = 0; k < 500; k++) begin
      for (int t = 0; t < NT; t++) begin
        if ($urandom_range(0, 3) == 0)
          set_tank(t, 10'($urandom_range(0, 700)), 10'($urandom_range(0, 520)),
                   8'($urandom), 8'($urandom));
      end
      bus.fire       = 2'($urandom);
      bus.wall_hit_x = 6'($urandom & $urandom);
      bus.wall_hit_y = 6'($urandom & $urandom);
      bus.hit_clear  = 6'($urandom & $urandom & $urandom & $urandom);
      do_tick("rand");
      @(negedge clk);
      bus.fire       = 2'($urandom);
      bus.wall_hit_x = 6'($urandom);
      bus.wall_hit_y = 6'($urandom);
      bus.hit_clear  = 6'($urandom);
      @(posedge clk);
      #1;
      compare_all("idle");
    end

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #3 rst = 1'b1;
    #2;
    model_reset();
    compare_all("async rst");
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
